param_lifo: RTL and testbench

Parametrised synchronous LIFO (stack) buffer for the datapath exercises. Supports configurable data width and depth, registered pop data with a valid strobe, simultaneous push+pop (top replacement), occupancy count, an almost-full threshold, and sticky overflow/underflow error flags. It is the general-purpose stack for later designs, such as expression evaluators and return-address buffers, driven by a controller FSM.

---
 rtl/lifo_pkg.sv | 16 +
 rtl/lifo_mem.sv | 26 ++
 rtl/param_lifo.sv | 127 ++++++++++++
 tb/tb_param_lifo.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_pkg.sv
// Shared types and helpers for the parametrised LIFO.
package lifo_pkg;

   typedef enum logic [1:0] {
      OP_NOP,
      OP_PUSH,
      OP_POP,
      OP_SWAP
   } lifo_op_t;

   // Occupancy counter width: must hold 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/lifo_mem.sv
// Register array with one synchronous write port and one asynchronous read port.
module lifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // No reset: stale entries are never visible because count gates every read.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/param_lifo.sv
// Parametrised stack: push/pop/swap with registered pop data, occupancy flags and sticky errors.
module param_lifo
   import lifo_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       clr_err,
   output logic [WIDTH-1:0]           data_out,
   output logic                       pop_valid,
   output logic [WIDTH-1:0]           top,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_full,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int CW = cnt_w(DEPTH);
   localparam int AW = $clog2(DEPTH);

   function automatic lifo_op_t decode_op(input logic en_i, input logic push_i, input logic pop_i);
      if (!en_i) begin
         return OP_NOP;
      end
      case ({push_i, pop_i})
         2'b10:   return OP_PUSH;
         2'b01:   return OP_POP;
         2'b11:   return OP_SWAP;
         default: return OP_NOP;
      endcase
   endfunction

   lifo_op_t         op;
   logic [CW-1:0]    top_idx;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [AW-1:0]    raddr;
   logic [WIDTH-1:0] rdata;

   assign op          = decode_op(en, push, pop);
   assign empty       = (count == '0);
   assign full        = (count == CW'(DEPTH));
   assign almost_full = (count >= CW'(AF_LEVEL));

   // Index of the current top; only meaningful when not empty.
   assign top_idx = count - CW'(1);
   assign raddr   = AW'(top_idx);
   assign top     = empty ? '0 : rdata;

   always_comb begin
      we    = 1'b0;
      waddr = raddr;
      case (op)
         OP_PUSH: begin
            we    = !full;
            waddr = AW'(count);
         end
         OP_SWAP: we = !empty;
         default: we = 1'b0;
      endcase
   end

   lifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (data_in),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count     <= '0;
         data_out  <= '0;
         pop_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         pop_valid <= 1'b0;
         // Clear first so a coincident new error below takes precedence.
         if (clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end
         case (op)
            OP_PUSH: begin
               if (full) begin
                  overflow <= 1'b1;
               end else begin
                  count <= count + CW'(1);
               end
            end
            OP_POP: begin
               if (empty) begin
                  underflow <= 1'b1;
               end else begin
                  data_out  <= rdata;
                  pop_valid <= 1'b1;
                  count     <= count - CW'(1);
               end
            end
            OP_SWAP: begin
               // Empty swap passes the incoming word straight through.
               data_out  <= empty ? data_in : rdata;
               pop_valid <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_param_lifo.sv
// Scoreboard bench for param_lifo: two configurations share stimulus and are checked against a stack model.
module tb_param_lifo;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic        push = 1'b0;
   logic        pop = 1'b0;
   logic        clr_err = 1'b0;
   logic [15:0] din = '0;

   logic [7:0]  dout_a, top_a;
   logic [3:0]  cnt_a;
   logic        pv_a, e_a, f_a, af_a, ov_a, un_a;

   logic [15:0] dout_b, top_b;
   logic [2:0]  cnt_b;
   logic        pv_b, e_b, f_b, af_b, ov_b, un_b;

   int n_chk = 0;
   int n_err = 0;

   logic [15:0] mstk [2][8];
   int          mcnt [2];
   logic        mov [2];
   logic        mun [2];
   logic        mpv [2];
   logic [15:0] mdout [2];
   logic [15:0] sb0 [$];
   logic [15:0] sb1 [$];

   always #5 clk = ~clk;

   param_lifo #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(7)) u_dut_a (
      .clk(clk), .reset(reset), .en(en), .push(push), .pop(pop),
      .data_in(din[7:0]), .clr_err(clr_err), .data_out(dout_a), .pop_valid(pv_a),
      .top(top_a), .count(cnt_a), .empty(e_a), .full(f_a), .almost_full(af_a),
      .overflow(ov_a), .underflow(un_a)
   );

   param_lifo #(.WIDTH(16), .DEPTH(5), .AF_LEVEL(3)) u_dut_b (
      .clk(clk), .reset(reset), .en(en), .push(push), .pop(pop),
      .data_in(din), .clr_err(clr_err), .data_out(dout_b), .pop_valid(pv_b),
      .top(top_b), .count(cnt_b), .empty(e_b), .full(f_b), .almost_full(af_b),
      .overflow(ov_b), .underflow(un_b)
   );

   function automatic int dep(input int d);
      return (d == 0) ? 8 : 5;
   endfunction

   function automatic int afl(input int d);
      return (d == 0) ? 7 : 3;
   endfunction

   function automatic logic [15:0] mask(input int d);
      return (d == 0) ? 16'h00ff : 16'hffff;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         mcnt[d]  = 0;
         mov[d]   = 1'b0;
         mun[d]   = 1'b0;
         mpv[d]   = 1'b0;
         mdout[d] = '0;
      end
      sb0.delete();
      sb1.delete();
   endtask

   task automatic expect_pop(input int d, input logic [15:0] v);
      mpv[d]   = 1'b1;
      mdout[d] = v;
      if (d == 0) sb0.push_back(v);
      else        sb1.push_back(v);
   endtask

   task automatic model_step(input int d);
      logic [15:0] v;
      v      = din & mask(d);
      mpv[d] = 1'b0;
      if (clr_err) begin
         mov[d] = 1'b0;
         mun[d] = 1'b0;
      end
      if (en) begin
         if (push && !pop) begin
            if (mcnt[d] == dep(d)) mov[d] = 1'b1;
            else begin
               mstk[d][mcnt[d]] = v;
               mcnt[d]++;
            end
         end else if (!push && pop) begin
            if (mcnt[d] == 0) mun[d] = 1'b1;
            else begin
               mcnt[d]--;
               expect_pop(d, mstk[d][mcnt[d]]);
            end
         end else if (push && pop) begin
            if (mcnt[d] == 0) expect_pop(d, v);
            else begin
               expect_pop(d, mstk[d][mcnt[d]-1]);
               mstk[d][mcnt[d]-1] = v;
            end
         end
      end
   endtask

   task automatic mon(input int d, input logic [3:0] c, input logic e, input logic f,
                      input logic af, input logic ov, input logic un, input logic pv,
                      input logic [15:0] dout, input logic [15:0] tp);
      string p;
      logic [15:0] exp_top;
      logic [15:0] got;
      p       = (d == 0) ? "a" : "b";
      exp_top = (mcnt[d] == 0) ? 16'h0 : mstk[d][mcnt[d]-1];
      check({p, "_count"}, 32'(c), 32'(mcnt[d]));
      check({p, "_empty"}, 32'(e), 32'(mcnt[d] == 0));
      check({p, "_full"}, 32'(f), 32'(mcnt[d] == dep(d)));
      check({p, "_almost_full"}, 32'(af), 32'(mcnt[d] >= afl(d)));
      check({p, "_overflow"}, 32'(ov), 32'(mov[d]));
      check({p, "_underflow"}, 32'(un), 32'(mun[d]));
      check({p, "_pop_valid"}, 32'(pv), 32'(mpv[d]));
      check({p, "_top"}, 32'(tp), 32'(exp_top));
      check({p, "_data_out_hold"}, 32'(dout), 32'(mdout[d]));
      if (pv) begin
         if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
            check({p, "_unexpected_pop"}, 32'(1), 32'(0));
         end else begin
            got = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            check({p, "_sb_pop_data"}, 32'(dout), 32'(got));
         end
      end
   endtask

   // Reference model: advances on every sampled edge, cleared by reset.
   initial begin
      model_clear();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) model_clear();
         else begin
            model_step(0);
            model_step(1);
         end
      end
   end

   // Monitor: compares DUT outputs against the model on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            mon(0, cnt_a, e_a, f_a, af_a, ov_a, un_a, pv_a, 16'(dout_a), 16'(top_a));
            mon(1, 4'(cnt_b), e_b, f_b, af_b, ov_b, un_b, pv_b, dout_b, top_b);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic op(input logic e, input logic p, input logic q, input logic [15:0] d, input logic c);
      @(negedge clk);
      en = e; push = p; pop = q; din = d; clr_err = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      check("reset_count", 32'(cnt_a), 32'(0));
      check("reset_empty", 32'(e_a), 32'(1));
      check("reset_almost_full", 32'(af_a), 32'(0));
      check("reset_pop_valid", 32'(pv_a), 32'(0));
      check("reset_data_out", 32'(dout_a), 32'(0));
      check("reset_top", 32'(top_a), 32'(0));
      check("reset_overflow", 32'(ov_a | un_a), 32'(0));
      @(negedge clk);
      reset = 1'b0;

      for (int i = 1; i <= 8; i++) begin
         op(1, 1, 0, {8'(i), 8'(8'h11 * i)}, 0);
         check("fill_count", 32'(cnt_a), 32'(i));
         check("fill_almost_full", 32'(af_a), 32'(i >= 7));
         check("fill_full", 32'(f_a), 32'(i == 8));
         if (i == 5) check("b_full_at_5", 32'(f_b), 32'(1));
      end
      op(1, 1, 0, 16'h0099, 0);
      check("overflow_set", 32'(ov_a), 32'(1));
      check("overflow_top", 32'(top_a), 32'(8'h88));

      for (int k = 0; k < 8; k++) begin
         op(1, 0, 1, 16'h0, 0);
         check("drain_data", 32'(dout_a), 32'(8'(8'h11 * (8 - k))));
         check("drain_valid", 32'(pv_a), 32'(1));
      end
      op(1, 0, 1, 16'h0, 0);
      check("underflow_valid", 32'(pv_a), 32'(0));
      check("underflow_set", 32'(un_a), 32'(1));
      check("underflow_hold", 32'(dout_a), 32'(8'h11));
      op(0, 0, 0, 16'h0, 1);
      check("clr_err_both", 32'({ov_a, un_a}), 32'(0));

      op(1, 1, 0, 16'h10a1, 0);
      op(1, 1, 0, 16'h20b2, 0);
      op(1, 1, 1, 16'h30c3, 0);
      check("swap_data", 32'(dout_a), 32'(8'hb2));
      check("swap_top", 32'(top_a), 32'(8'hc3));
      check("swap_count", 32'(cnt_a), 32'(2));
      op(1, 0, 1, 16'h0, 0);
      op(1, 0, 1, 16'h0, 0);
      op(1, 1, 1, 16'h405e, 0);
      check("swap_empty_data", 32'(dout_a), 32'(8'h5e));
      check("swap_empty_valid", 32'(pv_a), 32'(1));
      check("swap_empty_count", 32'(cnt_a), 32'(0));

      for (int i = 0; i < 3; i++) op(1, 1, 0, 16'(16'h0101 * (i + 1)), 0);
      for (int i = 0; i < 5; i++) begin
         op(0, 1, 1, 16'hdead, 0);
         check("gated_count", 32'(cnt_a), 32'(3));
         check("gated_data_out", 32'(dout_a), 32'(8'h5e));
      end

      for (int i = 0; i < 6; i++) op(1, 1, 0, 16'(16'h0a0a + i), 0);
      check("ovf_again", 32'(ov_a), 32'(1));
      op(0, 0, 0, 16'h0, 1);
      check("clr_err_overflow", 32'(ov_a), 32'(0));
      op(1, 1, 0, 16'h00ee, 1);
      check("clr_err_vs_error", 32'(ov_a), 32'(1));

      for (int i = 0; i < 3; i++) op(1, 0, 1, 16'h0, 0);
      op(1, 1, 1, 16'h0077, 0);
      check("pre_reset_count", 32'(cnt_a), 32'(5));
      check("pre_reset_valid", 32'(pv_a), 32'(1));
      #1;
      en = 0; push = 0; pop = 0; clr_err = 0;
      reset = 1'b1;
      #1;
      check("async_count", 32'(cnt_a), 32'(0));
      check("async_empty", 32'(e_a), 32'(1));
      check("async_valid", 32'(pv_a), 32'(0));
      check("async_b_count", 32'(cnt_b), 32'(0));
      #5;
      reset = 1'b0;
      op(1, 1, 0, 16'h0042, 0);
      op(1, 0, 1, 16'h0, 0);
      check("post_reset_data", 32'(dout_a), 32'(8'h42));
      check("post_reset_valid", 32'(pv_a), 32'(1));

      for (int i = 0; i < 600; i++) begin
         op($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            16'($urandom), $urandom_range(0, 15) == 0);
      end
      for (int i = 0; i < 3; i++) op(0, 0, 0, 16'h0, 0);
      @(negedge clk);
      #1;
      check("sb_a_left", 32'(sb0.size()), 32'(0));
      check("sb_b_left", 32'(sb1.size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
